// File: rtl/bram_arbiter_pkg.sv
// Shared constants and types for the BRAM arbiter slice.
package bram_arbiter_pkg;

  localparam int MAX_REQ     = 8;
  localparam int STATS_WIDTH = 16;
  localparam int ID_WIDTH    = $clog2(MAX_REQ);

  typedef logic [ID_WIDTH-1:0] req_id_t;

  // Round-robin successor of the winner; the last requester wraps to 0.
  function automatic req_id_t next_ptr(input req_id_t g, input int n);
    return (int'(g) == n - 1) ? '0 : g + req_id_t'(1);
  endfunction

endpackage

// File: rtl/memory_bus.sv
// Single-port BRAM bus: address, write enable, write data out; read data back.
interface memory_bus #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] r_data;

  modport master (output addr, output we, output w_data, input r_data);
  modport slave  (input addr, input we, input w_data, output r_data);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning from ptr upward, modulo N.
module rr_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] gnt,
  output req_id_t      winner,
  output logic         any
);

  int idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      // ptr never exceeds N-1, so one subtraction completes the modulo.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        winner   = req_id_t'(idx);
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin sharing of one single-port BRAM among NUM_REQ requesters.
// Optional per-requester grant and conflict counters under BRAM_ARBITER_STATS_EN.
//
// Handshake: a requester holds req[i] until it sees gnt[i]; the access is accepted in
// the cycle req[i] & gnt[i]. An accepted read returns rvalid[i] with rdata exactly one
// cycle later; writes have no response.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rvalid,
  output logic [DATA_WIDTH-1:0]                rdata,
  memory_bus.master                            bus
`ifdef BRAM_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STATS_WIDTH-1:0]  grant_count,
  output logic [STATS_WIDTH-1:0]               conflict_count
`endif
);

  req_id_t              ptr;
  req_id_t              win;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_any;
  logic                 sel_we;
  logic                 pend_v;
  req_id_t              pend_id;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .winner (win),
    .any    (arb_any)
  );

  // Grants are suppressed while reset is asserted.
  assign gnt    = rst_n ? arb_gnt : '0;
  assign sel_we = |(arb_gnt & req_we);

  // One-hot AND-OR issue mux; an idle bus carries all zeros so nothing is written.
  always_comb begin
    bus.addr   = '0;
    bus.we     = 1'b0;
    bus.w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.addr   = req_addr[i];
        bus.we     = req_we[i];
        bus.w_data = req_wdata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      pend_v  <= 1'b0;
      pend_id <= '0;
    end else begin
      if (arb_any) ptr <= next_ptr(win, NUM_REQ);
      pend_v  <= arb_any & ~sel_we;
      pend_id <= win;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = pend_v && (int'(pend_id) == i);
    end
  end

  assign rdata = bus.r_data;

`ifdef BRAM_ARBITER_STATS_EN
  logic multi_req;
  assign multi_req = (req & (req - 1'b1)) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count    <= '0;
      conflict_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_gnt[i] && (grant_count[i] != '1))
          grant_count[i] <= grant_count[i] + STATS_WIDTH'(1);
      end
      if (multi_req && (conflict_count != '1))
        conflict_count <= conflict_count + STATS_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Table-driven bench for bram_arbiter with a behavioural BRAM and a read-response scoreboard.
module tb_bram_arbiter;
  import bram_arbiter_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NV = 25;

  typedef struct packed {
    logic [NR-1:0]         req;
    logic [NR-1:0]         we;
    logic [NR-1:0][AW-1:0] addr;
    logic [NR-1:0][DW-1:0] wdata;
    logic [NR-1:0]         exp_gnt;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]         req, req_we, gnt, rvalid;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]         rdata;
`ifdef BRAM_ARBITER_STATS_EN
  logic [NR-1:0][STATS_WIDTH-1:0] grant_count;
  logic [STATS_WIDTH-1:0]         conflict_count;
`endif

  memory_bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bus       (bus_if)
`ifdef BRAM_ARBITER_STATS_EN
    ,
    .grant_count    (grant_count),
    .conflict_count (conflict_count)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // behavioural BRAM: write-then-read ordering across cycles, 1-cycle read latency
  logic [DW-1:0] bram_mem [1024];
  logic [DW-1:0] bram_rq;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) bram_mem[i] = init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (bus_if.we) bram_mem[bus_if.addr] <= bus_if.w_data;
      bram_rq <= bram_mem[bus_if.addr];
    end
  end
  assign bus_if.r_data = bram_rq;

  // scoreboard
  logic [DW-1:0]   ref_mem [1024];
  logic [DW+2:0]   exp_q[$];
  int              checks = 0;
  int              failures = 0;
  vec_t            vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] w,
                              input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] g);
    vec_t v;
    v.req = r; v.we = w; v.exp_gnt = g;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.wdata[0] = d0; v.wdata[1] = d1; v.wdata[2] = d2;
    return v;
  endfunction

  // driver: non-requesting lanes carry random junk that must never reach the bus
  task automatic apply(input vec_t v);
    req = v.req;
    for (int i = 0; i < NR; i++) begin
      if (v.req[i]) begin
        req_we[i] = v.we[i]; req_addr[i] = v.addr[i]; req_wdata[i] = v.wdata[i];
      end else begin
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = AW'($urandom_range(0, 1023));
        req_wdata[i] = $urandom;
      end
    end
  endtask

  // compare one cycle's outputs, retire the due response, queue the next one
  task automatic check_cycle(input logic [NR-1:0] exp_gnt, input string tag);
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rd, exp_wd;
    logic [AW-1:0] exp_ad;
    logic          exp_we;
    logic [DW+2:0] e;
    exp_rv = '0; exp_rd = '0; exp_ad = '0; exp_we = 1'b0; exp_wd = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < NR; i++) exp_rv[i] = (int'(e[DW+2:DW]) == i);
      exp_rd = e[DW-1:0];
    end
    chk({tag, " rvalid"}, 64'(rvalid), 64'(exp_rv));
    if (exp_rv != '0) chk({tag, " rdata"}, 64'(rdata), 64'(exp_rd));
    chk({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
    for (int i = 0; i < NR; i++) begin
      if (exp_gnt[i]) begin
        exp_ad = req_addr[i]; exp_we = req_we[i]; exp_wd = req_wdata[i];
        if (req_we[i]) ref_mem[req_addr[i]] = req_wdata[i];
        else exp_q.push_back({3'(i), ref_mem[req_addr[i]]});
      end
    end
    chk({tag, " bus_addr"}, 64'(bus_if.addr), 64'(exp_ad));
    chk({tag, " bus_we"}, 64'(bus_if.we), 64'(exp_we));
    chk({tag, " bus_wdata"}, 64'(bus_if.w_data), 64'(exp_wd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    vecs[0]  = mk(3'b010, 3'b010, 10'h0, 10'h005, 10'h0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010);
    vecs[1]  = mk(3'b010, 3'b000, 10'h0, 10'h005, 10'h0, 32'h0, 32'h0, 32'h0, 3'b010);
    vecs[2]  = mk(3'b000, 3'b000, 10'h0, 10'h0, 10'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    vecs[3]  = mk(3'b100, 3'b100, 10'h0, 10'h0, 10'h007, 32'h0, 32'h0, 32'h1111_2222, 3'b100);
    for (int i = 0; i < 6; i++)
      vecs[4+i] = mk(3'b111, 3'b000, 10'h005, 10'h007, 10'h010, 32'h0, 32'h0, 32'h0,
                     3'(1 << (i % 3)));
    vecs[10] = mk(3'b000, 3'b000, 10'h0, 10'h0, 10'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    vecs[11] = mk(3'b001, 3'b000, 10'h3FF, 10'h0, 10'h0, 32'h0, 32'h0, 32'h0, 3'b001);
    vecs[12] = vecs[11];
    vecs[13] = vecs[11];
    vecs[14] = mk(3'b101, 3'b000, 10'h3FF, 10'h0, 10'h000, 32'h0, 32'h0, 32'h0, 3'b100);
    vecs[15] = mk(3'b101, 3'b000, 10'h3FF, 10'h0, 10'h000, 32'h0, 32'h0, 32'h0, 3'b001);
    vecs[16] = vecs[14];
    vecs[17] = vecs[10];
    vecs[18] = mk(3'b100, 3'b100, 10'h0, 10'h0, 10'h020, 32'h0, 32'h0, 32'hCAFEF00D, 3'b100);
    vecs[19] = mk(3'b011, 3'b000, 10'h020, 10'h007, 10'h0, 32'h0, 32'h0, 32'h0, 3'b001);
    vecs[20] = mk(3'b011, 3'b000, 10'h020, 10'h007, 10'h0, 32'h0, 32'h0, 32'h0, 3'b010);
    vecs[21] = vecs[10];
    vecs[22] = mk(3'b011, 3'b001, 10'h100, 10'h100, 10'h0, 32'h0BADF00D, 32'h0, 32'h0, 3'b001);
    vecs[23] = mk(3'b010, 3'b000, 10'h0, 10'h100, 10'h0, 32'h0, 32'h0, 32'h0, 3'b010);
    vecs[24] = vecs[10];

    // reset with all requests up: no grant may leak out
    req = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", 64'(gnt), 64'(0));
    chk("reset rvalid", 64'(rvalid), 64'(0));
    chk("reset bus_we", 64'(bus_if.we), 64'(0));
    req = '0;
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      apply(vecs[10]);
      @(negedge clk);
      check_cycle(3'b000, $sformatf("idle%0d", c));
    end

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check_cycle(vecs[i].exp_gnt, $sformatf("v%0d", i));
    end

    // in-flight read dropped by a mid-cycle reset pulse
    @(posedge clk); #1;
    apply(mk(3'b010, 3'b000, 10'h0, 10'h005, 10'h0, 32'h0, 32'h0, 32'h0, 3'b010));
    @(negedge clk);
    check_cycle(3'b010, "rst_rd");
    @(posedge clk); #1;
    apply(mk(3'b111, 3'b000, 10'h005, 10'h007, 10'h010, 32'h0, 32'h0, 32'h0, 3'b000));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst rvalid", 64'(rvalid), 64'(0));
    chk("midrst gnt", 64'(gnt), 64'(0));
    chk("midrst bus_we", 64'(bus_if.we), 64'(0));
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_cycle(3'b001, "post_rst");
    @(posedge clk); #1;
    apply(vecs[10]);
    @(negedge clk);
    check_cycle(3'b000, "post_rst_rsp");

`ifdef BRAM_ARBITER_STATS_EN
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("stats rst conflict", 64'(conflict_count), 64'(0));
    chk("stats rst grant0", 64'(grant_count[0]), 64'(0));
    #2 rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      apply(mk(3'b111, 3'b000, 10'h001, 10'h002, 10'h003, 32'h0, 32'h0, 32'h0, 3'b000));
      @(negedge clk);
      check_cycle(3'(1 << (c % 3)), $sformatf("stats%0d", c));
    end
    @(posedge clk); #1;
    apply(vecs[10]);
    @(negedge clk);
    check_cycle(3'b000, "stats_drain");
    for (int i = 0; i < NR; i++)
      chk($sformatf("grant_count%0d", i), 64'(grant_count[i]), 64'(3));
    chk("conflict_count", 64'(conflict_count), 64'(9));
`endif

    chk("scoreboard empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
